pc_msg_parser: RTL

PC_MSG_PARSER -- requirements
Module: pc_msg_parser

---
 rtl/pc_msg_parser.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pc_msg_parser.sv
// pc_msg_parser: frames 3-word PC messages from a FWFT FIFO into
// START/STOP commands with a valid/ready hold and an inter-word timeout.
module pc_msg_parser #(
    parameter int DELAY   = 1,
    parameter int XB_SIZE = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               pc_msg_valid,
    input  logic [XB_SIZE-1:0] pc_msg,
    output logic               pc_msg_ack,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               cmd_start,
    output logic               cmd_stop,
    output logic [XB_SIZE-1:0] cmd_w0,
    output logic [XB_SIZE-1:0] cmd_w1,
    output logic [XB_SIZE-1:0] cmd_w2,
    output logic               running,
    output logic               err_timeout,
    output logic [15:0]        msg_count
);

    // Registers update without a modelled delay; DELAY stays for compatibility.
    logic unused_delay;
    assign unused_delay = (DELAY != 0);

    // Counter only ever holds 0..TIMEOUT-1: the idle cycle that would
    // reach TIMEOUT is the one that discards the message.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        W0   = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [XB_SIZE-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
    logic               start_q, start_d, stop_q, stop_d;
    logic               running_q, running_d;
    logic               err_q, err_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [15:0]        count_q, count_d;
    logic               ack;

    // Pop only while collecting words and never during reset.
    assign ack = pc_msg_valid && RESET && (state_q != HOLD);

    // Next-state, word capture, decode, timeout and accept bookkeeping.
    always_comb begin
        state_d   = state_q;
        w0_d      = w0_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        start_d   = start_q;
        stop_d    = stop_q;
        running_d = running_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        count_d   = count_q;
        unique case (state_q)
            W0: begin
                cnt_d = '0;
                if (ack) begin
                    w0_d    = pc_msg;
                    state_d = W1;
                end
            end
            W1, W2: begin
                if (ack) begin
                    cnt_d = '0;
                    if (state_q == W1) begin
                        w1_d    = pc_msg;
                        state_d = W2;
                    end else begin
                        w2_d    = pc_msg;
                        stop_d  = (w0_q == '0) && (w1_q == '0) && (pc_msg == '0);
                        start_d = !((w0_q == '0) && (w1_q == '0) && (pc_msg == '0));
                        state_d = HOLD;
                    end
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    w0_d    = '0;
                    w1_d    = '0;
                    w2_d    = '0;
                    state_d = W0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (cmd_ready) begin
                    running_d = start_q;
                    count_d   = count_q + 16'd1;
                    start_d   = 1'b0;
                    stop_d    = 1'b0;
                    state_d   = W0;
                end
            end
            default: begin
                state_d = W0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= W0;
            w0_q      <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            w0_q      <= w0_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            running_q <= running_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
        end
    end

    assign pc_msg_ack  = ack;
    assign cmd_valid   = (state_q == HOLD);
    assign cmd_start   = start_q;
    assign cmd_stop    = stop_q;
    assign cmd_w0      = w0_q;
    assign cmd_w1      = w1_q;
    assign cmd_w2      = w2_q;
    assign running     = running_q;
    assign err_timeout = err_q;
    assign msg_count   = count_q;

endmodule
